snn_timestep_scheduler: RTL

Sequences one SNN inference run over a configurable number of timesteps for the SNN core. Each timestep it requests an input spike vector, then starts each layer in order and waits for that layer to finish. It accumulates output-neuron spikes into per-output counters and reports the winning output (argmax). It sits between the AXI config registers (start, timestep count, results) and the neuron layer datapath.

---
 rtl/snn_timestep_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/snn_timestep_scheduler.sv
// Run sequencer for the SNN core: fetch input, step each layer, accumulate output spikes, pick argmax.
// Optional handshake watchdog enabled by defining SNN_SCHED_TIMEOUT_EN.
module snn_timestep_scheduler #(
   parameter int NUM_LAYERS     = 1,
   parameter int NUM_OUTPUTS    = 2,
   parameter int TS_WIDTH       = 16,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int LSEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
   localparam int WIN_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                             S_AXI_ACLK,
   input  logic                             S_AXI_ARESETN,
   input  logic                             start,
   input  logic                             abort,
   input  logic [TS_WIDTH-1:0]              num_timesteps,
   output logic                             busy,
   output logic                             done,
   output logic [TS_WIDTH-1:0]              timestep,
   output logic                             neuron_rst,
   output logic                             in_req,
   input  logic                             in_ack,
   output logic                             layer_start,
   output logic [LSEL_W-1:0]                layer_sel,
   input  logic                             layer_done,
   input  logic [NUM_OUTPUTS-1:0]           out_spikes,
   output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] spike_counts,
   output logic [WIN_W-1:0]                 winner,
   output logic                             err
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FETCH, S_LAYER_GO, S_LAYER_WAIT, S_ACCUM, S_RESOLVE, S_DONE
   } state_t;

   state_t                                  state, state_nxt;
   logic [TS_WIDTH-1:0]                     t_q;
   logic [NUM_OUTPUTS-1:0][CNT_WIDTH-1:0]   cnt_q;
   logic [WIN_W-1:0]                        best_idx;
   logic [CNT_WIDTH-1:0]                    best_val;
   logic                                    last_layer, last_ts, timeout, freeze;

   assign last_layer   = (layer_sel == LSEL_W'(NUM_LAYERS - 1));
   assign last_ts      = (timestep == t_q - TS_WIDTH'(1));
   assign spike_counts = cnt_q;
   // abort cancels the run without disturbing counts, winner or indices
   assign freeze       = abort && (state != S_IDLE);

`ifdef SNN_SCHED_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              err_q;

   assign waiting = ((state == S_FETCH) && !in_ack) || ((state == S_LAYER_WAIT) && !layer_done);
   assign timeout = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
         if ((state == S_IDLE) && start) err_q <= 1'b0;
         else if (timeout && !abort)     err_q <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout        = 1'b0;
   assign err            = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      busy        = 1'b1;
      done        = 1'b0;
      neuron_rst  = 1'b0;
      in_req      = 1'b0;
      layer_start = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            neuron_rst = 1'b1;
            state_nxt  = (t_q == '0) ? S_RESOLVE : S_FETCH;
         end
         S_FETCH: begin
            in_req = 1'b1;
            if (in_ack) state_nxt = S_LAYER_GO;
         end
         S_LAYER_GO: begin
            layer_start = 1'b1;
            state_nxt   = S_LAYER_WAIT;
         end
         S_LAYER_WAIT: if (layer_done) state_nxt = last_layer ? S_ACCUM : S_LAYER_GO;
         S_ACCUM:      state_nxt = last_ts ? S_RESOLVE : S_FETCH;
         S_RESOLVE:    state_nxt = S_DONE;
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if ((state != S_IDLE) && (abort || timeout)) state_nxt = S_IDLE;
   end

   // strict '>' keeps the lowest index on ties
   always_comb begin
      best_idx = '0;
      best_val = cnt_q[0];
      for (int i = 1; i < NUM_OUTPUTS; i++) begin
         if (cnt_q[i] > best_val) begin
            best_val = cnt_q[i];
            best_idx = WIN_W'(i);
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state     <= S_IDLE;
         t_q       <= '0;
         timestep  <= '0;
         layer_sel <= '0;
         cnt_q     <= '0;
         winner    <= '0;
      end else begin
         state <= state_nxt;
         if (!freeze) begin
            case (state)
               S_IDLE: if (start) t_q <= num_timesteps;
               S_CLEAR: begin
                  cnt_q     <= '0;
                  timestep  <= '0;
                  layer_sel <= '0;
               end
               S_LAYER_WAIT: if (layer_done && !last_layer) layer_sel <= layer_sel + LSEL_W'(1);
               S_ACCUM: begin
                  for (int i = 0; i < NUM_OUTPUTS; i++)
                     if (out_spikes[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}}))
                        cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                  layer_sel <= '0;
                  if (!last_ts) timestep <= timestep + TS_WIDTH'(1);
               end
               S_RESOLVE: winner <= best_idx;
               default: ;
            endcase
         end
      end
   end

endmodule
